seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised sequential integer divider for the multi-cycle CPU datapath, serving both `div` and `divu`. Uses a restoring shift-subtract algorithm with fixed latency independent of operand values. Results go to HI/LO: remainder to HI, quotient to LO. Sits beside the multiplier under control-unit handshake (start/done), with a divide-by-zero flag routed to the exception logic.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be at least 2.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high; clock `clock`.
- `start`  in  1: request a division; sampled only in IDLE.
- `is_signed`  in  1: 1 = two's-complement (`div`), 0 = unsigned (`divu`); sampled with `start`.
- `dividend`  in  WIDTH: numerator (RegA); sampled with `start`.
- `divisor`  in  WIDTH: denominator (RegB); sampled with `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when `hi`/`lo` become valid.
- `div_zero`  out  1: set with `done` when divisor == 0; held until next accepted `start` or reset.
- `hi`  out  WIDTH: remainder; held until next completion.
- `lo`  out  WIDTH: quotient; held until next completion.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start`=1:
  - latch `is_signed`; latch sign bits (forced 0 when unsigned); latch magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values (|MIN| = 2^(WIDTH-1)).
  - clear `div_zero`; clear iteration counter.
  - divisor == 0: go straight to a completion cycle. Next edge: `done`=1, `div_zero`=1, `hi`=`lo`=DIV0_FILL (0 followed by WIDTH-1 ones). Return to IDLE.
  - otherwise go to RUN.
- RUN, one bit per cycle, MSB first, for WIDTH cycles:
  - partial remainder R is WIDTH+1 bits; R' = {R, next dividend bit}.
  - if R' >= divisor magnitude: R = R' − divisor, quotient bit 1; else R = R', quotient bit 0.
  - counter reaching WIDTH−1 → FIX.
- FIX:
  - `lo` = quotient, negated if signs differ.
  - `hi` = remainder, negated if dividend was negative.
  - `done`=1 for this single cycle; go to IDLE.
- Signed semantics:
  - quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / −1 wraps naturally: `lo`=MIN, `hi`=0, no flag.
- `start` while busy is ignored; operand changes during RUN have no effect.
- `start` in the same cycle `done` is high: accepted, because the block is in IDLE that cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Normal latency: start sampled at edge k → RUN for edges k+1..k+WIDTH → FIX outputs registered at edge k+WIDTH+1. `done` is high during cycle k+WIDTH+1 (33 cycles after start for WIDTH=32).
- Divide-by-zero latency: `done` and `div_zero` high after edge k+1.
- `busy` rises at edge k and falls at the edge that ends the `done` cycle.
- Reset mid-operation: abort, restore all reset values, no `done` pulse.
- `hi`/`lo` are registered and change only in the completion cycle.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, RUN, FIX}.
  - function `div0_fill(WIDTH)`.
  - helper `abs_val` for two's-complement magnitude.
- Sub-module `div_step`: combinational single-iteration restoring step.
  - inputs: R, next dividend bit, divisor magnitude.
  - outputs: new R, quotient bit.
  - parametrised on WIDTH; instantiated once.

## Test plan
- Signed 100 / 7 → `lo`=14, `hi`=2, `done` exactly 33 cycles after `start`, `busy` high throughout.
- Signed −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; signed 7 / −2 → `lo`=0xFFFFFFFD, `hi`=1.
- 0xFFFFFFFF / 2: unsigned → `lo`=0x7FFFFFFF, `hi`=1; signed → `lo`=0, `hi`=0xFFFFFFFF.
- Any / 0 → `done`+`div_zero` one cycle after `start`, `hi`=`lo`=0x7FFFFFFF; following 9 / 3 → `div_zero` clears, `lo`=3, `hi`=0.
- Signed 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- Pulse `start` with new operands at cycle 10 of a run → ignored. Assert `reset` at cycle 20 → no `done`, all outputs 0. Repeat with WIDTH=8: 200/13 unsigned → `lo`=15, `hi`=5, `done` 9 cycles after `start`.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Width-generic helpers operate on MAX_W bits; callers truncate to their WIDTH (WIDTH <= MAX_W).
package div_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // 0 followed by width-1 ones (the most positive two's-complement value).
  function automatic logic [MAX_W-1:0] div0_fill(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // Two's-complement magnitude; the low width bits are correct for any width <= MAX_W.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Remainder stays below the divisor, so it fits in WIDTH bits; only the shifted value needs WIDTH+1.
  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_dsr});
  assign w_diff  = w_shift[WIDTH-1:0] - i_dsr;
  assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_qbit  = w_ge;

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency sequential divider for div/divu: remainder to hi, quotient to lo,
// start/done handshake and a divide-by-zero flag for the exception logic.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import div_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DIV0_FILL = WIDTH'(div0_fill(WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_pend;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;

  assign w_neg_a = is_signed & dividend[WIDTH-1];
  assign w_neg_b = is_signed & divisor[WIDTH-1];
  assign w_mag_a = WIDTH'(abs_val(MAX_W'(dividend), w_neg_a));
  assign w_mag_b = WIDTH'(abs_val(MAX_W'(divisor), w_neg_b));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_rem      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_dvd      <= w_mag_a;
            r_dsr      <= w_mag_b;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_dz_pend  <= (divisor == '0);
            r_busy     <= 1'b1;
            r_state    <= (divisor == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          // Quotient bits shift in behind the consumed dividend bits.
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_rem <= w_rem_next;
          if (r_cnt == LAST_CNT) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          if (r_dz_pend) begin
            r_hi       <= DIV0_FILL;
            r_lo       <= DIV0_FILL;
            r_div_zero <= 1'b1;
          end else begin
            r_lo <= r_neg_q ? -r_dvd : r_dvd;
            r_hi <= r_neg_r ? -r_rem : r_rem;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8 with directed vectors.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s32, sg32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        s8, sg8, busy8, done8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  seq_divider #(.WIDTH(32)) u_div32 (
    .clock(clk), .reset(rst), .start(s32), .is_signed(sg32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  seq_divider #(.WIDTH(8)) u_div8 (
    .clock(clk), .reset(rst), .start(s8), .is_signed(sg8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          stamp;
    int          lat;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        check("w32 unexpected done", {31'b0, done32}, 32'd0);
      end else begin
        e = q32.pop_front();
        check({e.name, " lo"}, lo32, e.lo);
        check({e.name, " hi"}, hi32, e.hi);
        check({e.name, " div_zero"}, {31'b0, dz32}, {31'b0, e.dz});
        check({e.name, " latency"}, cyc - e.stamp, e.lat);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8 unexpected done", {31'b0, done8}, 32'd0);
      end else begin
        e = q8.pop_front();
        check({e.name, " lo"}, {24'b0, lo8}, e.lo);
        check({e.name, " hi"}, {24'b0, hi8}, e.hi);
        check({e.name, " div_zero"}, {31'b0, dz8}, {31'b0, e.dz});
        check({e.name, " latency"}, cyc - e.stamp, e.lat);
      end
    end
  end

  // Called at a negedge; start is sampled by the following posedge.
  task automatic op32(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
    exp_t e;
    e.lo = elo; e.hi = ehi; e.dz = edz; e.stamp = cyc + 1; e.lat = edz ? 1 : 33; e.name = nm;
    q32.push_back(e);
    s32 = 1'b1; sg32 = sg; a32 = a; b32 = b;
    @(negedge clk);
    s32 = 1'b0; sg32 = ~sg; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic op8(input string nm, input logic sg, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] elo, input logic [7:0] ehi, input logic edz);
    exp_t e;
    e.lo = {24'b0, elo}; e.hi = {24'b0, ehi}; e.dz = edz; e.stamp = cyc + 1;
    e.lat = edz ? 1 : 9; e.name = nm;
    q8.push_back(e);
    s8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    @(negedge clk);
    s8 = 1'b0; sg8 = ~sg; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done32(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (done32) return;
      check({nm, " busy"}, {31'b0, busy32}, 32'd1);
      @(negedge clk);
    end
    check({nm, " timeout"}, {31'b0, done32}, 32'd1);
  endtask

  task automatic wait_done8(input string nm);
    for (int i = 0; i < 30; i++) begin
      if (done8) return;
      check({nm, " busy"}, {31'b0, busy8}, 32'd1);
      @(negedge clk);
    end
    check({nm, " timeout"}, {31'b0, done8}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    s32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    s8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy32}, 32'd0);
    check("reset done", {31'b0, done32}, 32'd0);
    check("reset div_zero", {31'b0, dz32}, 32'd0);
    check("reset hi", hi32, 32'd0);
    check("reset lo", lo32, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op32("s100/7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done32("s100/7");
    op32("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_done32("s-7/2");
    op32("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_done32("s7/-2");
    op32("uFFFFFFFF/2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_done32("uFFFFFFFF/2");
    op32("sFFFFFFFF/2", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_done32("sFFFFFFFF/2");
    op32("sMIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    wait_done32("sMIN/-1");
    op32("u1234/0", 1'b0, 32'd1234, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    wait_done32("u1234/0");
    repeat (2) @(negedge clk);
    check("div_zero held", {31'b0, dz32}, 32'd1);
    check("fill lo held", lo32, 32'h7FFF_FFFF);
    op32("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_done32("u9/3");
    op32("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    wait_done32("s-5/0");
    op32("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    wait_done32("s-100/7");

    // A start pulse mid-run must be ignored: only one completion is expected.
    op32("u1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    s32 = 1'b1; sg32 = 1'b1; a32 = 32'd5; b32 = 32'd5;
    @(negedge clk);
    s32 = 1'b0;
    wait_done32("u1000/10");
    repeat (2) @(negedge clk);
    check("ignored start busy", {31'b0, busy32}, 32'd0);

    // Reset mid-operation: no completion, all outputs cleared.
    s32 = 1'b1; sg32 = 1'b0; a32 = 32'd77; b32 = 32'd7;
    @(negedge clk);
    s32 = 1'b0;
    repeat (18) @(negedge clk);
    check("pre-reset busy", {31'b0, busy32}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset busy", {31'b0, busy32}, 32'd0);
    check("mid reset done", {31'b0, done32}, 32'd0);
    check("mid reset div_zero", {31'b0, dz32}, 32'd0);
    check("mid reset hi", hi32, 32'd0);
    check("mid reset lo", lo32, 32'd0);
    repeat (40) @(negedge clk);
    check("post reset lo", lo32, 32'd0);

    op32("u45/6 after reset", 1'b0, 32'd45, 32'd6, 32'd7, 32'd3, 1'b0);
    wait_done32("u45/6 after reset");

    op8("w8 u200/13", 1'b0, 8'd200, 8'd13, 8'd15, 8'd5, 1'b0);
    wait_done8("w8 u200/13");
    op8("w8 sMIN/-1", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    wait_done8("w8 sMIN/-1");
    op8("w8 s-9/0", 1'b1, 8'hF7, 8'h00, 8'h7F, 8'h7F, 1'b1);
    wait_done8("w8 s-9/0");
    op8("w8 s-9/4", 1'b1, 8'hF7, 8'h04, 8'hFE, 8'hFF, 1'b0);
    wait_done8("w8 s-9/4");

    repeat (3) @(negedge clk);
    check("w32 queue drained", q32.size(), 32'd0);
    check("w8 queue drained", q8.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
